// File: rtl/iob_clkdiv_pkg.sv
// Shared state encoding and constants for the programmable clock divider.
// Keeps the FSM encoding and the minimum ratio in one place for RTL and bench.
package iob_clkdiv_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DIV_MIN = 2;

endpackage

// File: rtl/iob_clkdiv.sv
// Glitch-free programmable divider: flop-driven clk_out plus a source-domain tick, 1-edge start latency.
// No backpressure; ratio and enable changes are only acted on at period boundaries.
module iob_clkdiv
   import iob_clkdiv_pkg::*;
#(
   parameter int DIV_W   = 8,
   parameter int DIV_RST = 2
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             clk_out,
   output logic             tick,
   output logic             active
);

   state_t           state, state_nxt;
   logic [DIV_W-1:0] d_a, d_a_nxt;
   logic [DIV_W-1:0] cnt, cnt_nxt;
   logic             clk_out_nxt;
   logic             tick_nxt;

   logic [DIV_W-1:0] div_clamped;
   logic [DIV_W:0]   half_len;
   logic             high_last;
   logic             period_end;

   assign div_clamped = (div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div;
   // One extra bit so ceil(D/2) cannot wrap at the maximum ratio.
   assign half_len    = ({1'b0, d_a} + (DIV_W+1)'(1)) >> 1;
   assign high_last   = ({1'b0, cnt} == (half_len - (DIV_W+1)'(1)));
   assign period_end  = (cnt == (d_a - DIV_W'(1)));

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state   <= IDLE;
         d_a     <= DIV_W'(DIV_RST);
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else begin
         state   <= state_nxt;
         d_a     <= d_a_nxt;
         cnt     <= cnt_nxt;
         clk_out <= clk_out_nxt;
         tick    <= tick_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      d_a_nxt     = d_a;
      cnt_nxt     = cnt;
      clk_out_nxt = clk_out;
      tick_nxt    = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt     = '0;
            clk_out_nxt = 1'b0;
            if (en) begin
               state_nxt   = RUN;
               d_a_nxt     = div_clamped;
               clk_out_nxt = 1'b1;
               tick_nxt    = 1'b1;
            end
         end
         RUN: begin
            if (period_end) begin
               // clk_out is already low here since H-1 < D-1 for every D >= 2.
               cnt_nxt     = '0;
               clk_out_nxt = 1'b0;
               if (en) begin
                  d_a_nxt     = div_clamped;
                  clk_out_nxt = 1'b1;
                  tick_nxt    = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + DIV_W'(1);
               if (high_last) clk_out_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            clk_out_nxt = 1'b0;
         end
      endcase
   end

   assign active = (state == RUN);

endmodule
